risc_v_mike_imem_loader: RTL and testbench

- Writer-side partner of the instruction memory.
- Accepts a byte stream (valid/ready) from a host or boot UART and packs it little-endian into 32-bit words.
- Drives the instruction memory write port at sequential addresses from 0.
- Holds the core in reset until the program image is fully loaded.

---
 rtl/risc_v_mike_imem_loader_pkg.sv | 20 ++
 rtl/risc_v_mike_imem_loader_if.sv | 32 +++
 rtl/risc_v_mike_imem_loader_byte_packer.sv | 63 ++++++
 rtl/risc_v_mike_imem_loader.sv | 168 ++++++++++++++++
 tb/tb_risc_v_mike_imem_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/risc_v_mike_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package risc_v_mike_imem_loader_pkg;

    localparam int DATA_32_W           = 32;
    localparam int IMEM_BYTE_W         = 8;
    localparam int IMEM_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } t_imem_ldr_state;

    // An image length is usable when it is non-zero and fits in the memory.
    function automatic logic imem_len_legal(input logic [31:0] len, input logic [31:0] depth);
        return (len != 32'd0) && (len <= depth);
    endfunction

endpackage

// File: rtl/risc_v_mike_imem_loader_if.sv
// Host byte stream, instruction-memory write port and core control flags.
interface risc_v_mike_imem_loader_if #(
    parameter int DATA_MEM_DEPTH = 16,
    parameter int ADDR_W         = $clog2(DATA_MEM_DEPTH)
) ();
    import risc_v_mike_imem_loader_pkg::*;

    logic                 start;
    logic [ADDR_W:0]      num_words;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 imem_wr_en;
    logic [ADDR_W-1:0]    imem_wr_addr;
    logic [DATA_32_W-1:0] imem_wr_data;
    logic                 core_hold;
    logic                 load_done;
    logic                 load_error;

    modport master (
        output start, num_words, byte_valid, byte_data,
        input  byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        input  core_hold, load_done, load_error
    );

    modport slave (
        input  start, num_words, byte_valid, byte_data,
        output byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        output core_hold, load_done, load_error
    );

endinterface

// File: rtl/risc_v_mike_imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and emits a one-cycle
// word-complete pulse together with a stable copy of the finished word, so
// bytes of the next word can arrive while the previous word is being written.
module risc_v_mike_byte_packer
    import risc_v_mike_imem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 byte_acc,
    input  logic [7:0]           byte_data,
    output logic                 word_last_byte,
    output logic                 word_valid,
    output logic [DATA_32_W-1:0] word_data
);

    localparam int CNT_W = $clog2(IMEM_BYTES_PER_WORD);

    logic [CNT_W-1:0]     byte_cnt_r;
    logic [DATA_32_W-1:0] pack_r;
    logic [DATA_32_W-1:0] pack_next_s;
    logic                 word_valid_r;
    logic [DATA_32_W-1:0] word_data_r;

    assign word_last_byte = byte_acc && (byte_cnt_r == CNT_W'(IMEM_BYTES_PER_WORD - 1));

    // Merge the incoming byte into its lane of the pack register.
    always_comb begin
        pack_next_s = pack_r;
        if (byte_acc) begin
            pack_next_s[IMEM_BYTE_W*byte_cnt_r +: IMEM_BYTE_W] = byte_data;
        end else begin
            pack_next_s = pack_r;
        end
    end

    // Byte lane counter, pack register and the registered word hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r   <= {CNT_W{1'b0}};
            pack_r       <= {DATA_32_W{1'b0}};
            word_valid_r <= 1'b0;
            word_data_r  <= {DATA_32_W{1'b0}};
        end else if (clr) begin
            byte_cnt_r   <= {CNT_W{1'b0}};
            pack_r       <= {DATA_32_W{1'b0}};
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= word_last_byte;
            if (byte_acc) begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                pack_r     <= pack_next_s;
            end
            if (word_last_byte) begin
                word_data_r <= pack_next_s;
            end
        end
    end

    assign word_valid = word_valid_r;
    assign word_data  = word_data_r;

endmodule

// File: rtl/risc_v_mike_imem_loader.sv
// Boot loader: streams a byte image into the instruction memory starting at
// word 0 and keeps the core in reset until the whole image has been written.
module risc_v_mike_imem_loader
    import risc_v_mike_imem_loader_pkg::*;
#(
    parameter int DATA_MEM_DEPTH = 16,
    parameter int ADDR_W         = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    risc_v_mike_imem_loader_if.slave  bus
);

    t_imem_ldr_state state_r;
    t_imem_ldr_state state_next_s;

    logic [ADDR_W:0]   num_words_r;
    logic [ADDR_W:0]   word_cnt_r;
    logic [ADDR_W-1:0] imem_wr_addr_r;

    logic byte_ready_r;
    logic core_hold_r;
    logic load_done_r;
    logic load_error_r;

    logic byte_ready_s;
    logic core_hold_s;
    logic load_done_s;
    logic load_error_s;

    logic                 len_legal_s;
    logic                 start_seen_s;
    logic                 start_load_s;
    logic                 byte_acc_s;
    logic                 word_last_byte_s;
    logic                 final_byte_s;
    logic                 word_valid_s;
    logic [DATA_32_W-1:0] word_data_s;

    assign len_legal_s  = imem_len_legal(32'(bus.num_words), 32'(DATA_MEM_DEPTH));
    assign start_seen_s = bus.start && (state_r != LOAD);
    assign start_load_s = start_seen_s && len_legal_s;
    assign byte_acc_s   = bus.byte_valid && byte_ready_r;
    assign final_byte_s = word_last_byte_s &&
                          (word_cnt_r == (num_words_r - {{ADDR_W{1'b0}}, 1'b1}));

    risc_v_mike_byte_packer u_packer (
        .clk            (clk),
        .rst            (rst),
        .clr            (start_load_s),
        .byte_acc       (byte_acc_s),
        .byte_data      (bus.byte_data),
        .word_last_byte (word_last_byte_s),
        .word_valid     (word_valid_s),
        .word_data      (word_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: start leaves any non-LOAD state, the final byte ends LOAD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_next_s = len_legal_s ? LOAD : ERR;
                end else begin
                    state_next_s = state_r;
                end
            end
            LOAD: begin
                if (final_byte_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = LOAD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs decoded from the next state so the flags can be registered
    // and still line up with the state they describe.
    always_comb begin
        byte_ready_s = 1'b0;
        core_hold_s  = 1'b1;
        load_done_s  = 1'b0;
        load_error_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                core_hold_s = 1'b1;
            end
            LOAD: begin
                byte_ready_s = 1'b1;
                core_hold_s  = 1'b1;
            end
            DONE: begin
                core_hold_s = 1'b0;
                load_done_s = 1'b1;
            end
            ERR: begin
                core_hold_s  = 1'b1;
                load_error_s = 1'b1;
            end
            default: begin
                byte_ready_s = 1'b0;
                core_hold_s  = 1'b1;
            end
        endcase
    end

    // Registered handshake and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready_r <= 1'b0;
            core_hold_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_s;
            core_hold_r  <= core_hold_s;
            load_done_r  <= load_done_s;
            load_error_r <= load_error_s;
        end
    end

    // Image length latch and running word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_words_r <= {(ADDR_W+1){1'b0}};
            word_cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (start_seen_s) begin
                num_words_r <= bus.num_words;
            end
            if (start_load_s) begin
                word_cnt_r <= {(ADDR_W+1){1'b0}};
            end else if (word_last_byte_s) begin
                word_cnt_r <= word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Capture the write address alongside the packer's word hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_wr_addr_r <= {ADDR_W{1'b0}};
        end else if (word_last_byte_s) begin
            imem_wr_addr_r <= word_cnt_r[ADDR_W-1:0];
        end
    end

    assign bus.byte_ready   = byte_ready_r;
    assign bus.imem_wr_en   = word_valid_s;
    assign bus.imem_wr_addr = imem_wr_addr_r;
    assign bus.imem_wr_data = word_data_s;
    assign bus.core_hold    = core_hold_r;
    assign bus.load_done    = load_done_r;
    assign bus.load_error   = load_error_r;

endmodule

// File: tb/tb_risc_v_mike_imem_loader.sv
// Randomized self-checking bench for the instruction-memory loader. A
// transaction-level model tracks the load phase and total byte count and
// predicts every cycle's write strobe, address, data and status flags.
module tb_risc_v_mike_imem_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_DONE = 2;
    localparam int PH_ERR  = 3;

    logic clk;
    logic rst;

    risc_v_mike_imem_loader_if #(.DATA_MEM_DEPTH(DEPTH)) bus ();

    risc_v_mike_imem_loader #(.DATA_MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors_applied = 0;
    int miscompares     = 0;

    int          m_phase = PH_IDLE;
    int          m_nw    = 0;
    int          m_bytes = 0;
    logic [31:0] m_word  = 32'd0;
    logic        m_acc   = 1'b0;
    logic        exp_wr  = 1'b0;
    int          exp_addr = 0;
    logic [31:0] exp_data = 32'd0;

    logic [31:0] img [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict the effect of the currently driven inputs, then
    // compare every output just after the edge.
    task automatic tick();
        int slot;
        exp_wr = 1'b0;
        m_acc  = 1'b0;
        if (rst) begin
            m_phase = PH_IDLE;
            m_bytes = 0;
            m_word  = 32'd0;
        end else if (bus.start && m_phase != PH_LOAD) begin
            if (bus.num_words >= 1 && bus.num_words <= DEPTH) begin
                m_phase = PH_LOAD;
                m_nw    = int'(bus.num_words);
                m_bytes = 0;
                m_word  = 32'd0;
            end else begin
                m_phase = PH_ERR;
            end
        end else if (m_phase == PH_LOAD && bus.byte_valid) begin
            m_acc   = 1'b1;
            slot    = m_bytes % 4;
            m_word  = m_word | (32'(bus.byte_data) << (8 * slot));
            m_bytes = m_bytes + 1;
            if (m_bytes % 4 == 0) begin
                exp_wr   = 1'b1;
                exp_addr = m_bytes / 4 - 1;
                exp_data = m_word;
                m_word   = 32'd0;
                if (m_bytes == 4 * m_nw) m_phase = PH_DONE;
            end
        end
        @(posedge clk);
        #1;
        chk("wr_en", 32'(bus.imem_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(bus.imem_wr_addr), 32'(exp_addr));
            chk("wr_data", bus.imem_wr_data, exp_data);
        end
        if (rst) begin
            chk("rst_addr", 32'(bus.imem_wr_addr), 32'd0);
            chk("rst_data", bus.imem_wr_data, 32'd0);
        end
        chk("byte_ready", 32'(bus.byte_ready), 32'(m_phase == PH_LOAD));
        chk("core_hold",  32'(bus.core_hold),  32'(m_phase != PH_DONE));
        chk("load_done",  32'(bus.load_done),  32'(m_phase == PH_DONE));
        chk("load_error", 32'(bus.load_error), 32'(m_phase == PH_ERR));
    endtask

    task automatic idle(input int n);
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stall (possibly with a stray start pulse), then hold the byte until taken.
    task automatic send_byte(input logic [7:0] b, input int stall_mode);
        int s;
        int tries;
        s = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
        bus.byte_valid = 1'b0;
        for (int i = 0; i < s; i++) begin
            if (stall_mode < 0 && $urandom_range(0, 7) == 0) begin
                bus.start     = 1'b1;
                bus.num_words = (AW+1)'($urandom_range(0, 17));
            end else begin
                bus.start = 1'b0;
            end
            tick();
            bus.start = 1'b0;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tries = 0;
        do begin
            tick();
            tries++;
        end while (!m_acc && tries < 20);
        if (!m_acc) chk("byte_timeout", 32'd0, 32'd1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_words(input int first, input int count, input int stall_mode);
        logic [31:0] w;
        for (int k = first; k < first + count; k++) begin
            w = img[k];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], stall_mode);
        end
    endtask

    task automatic pulse_start(input int nw);
        bus.start      = 1'b1;
        bus.num_words  = (AW+1)'(nw);
        bus.byte_valid = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_load(input int nw, input int stall_mode);
        pulse_start(nw);
        send_words(0, nw, stall_mode);
        idle(2);
    endtask

    initial begin
        int nw;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_words  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // Basic two-word image, back-to-back bytes.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        run_load(2, 0);

        // Same image with three idle cycles before every byte.
        run_load(2, 3);

        // Full depth, then extra bytes that must not be consumed.
        for (int k = 0; k < DEPTH; k++) img[k] = 32'hA5A5_0000 + 32'(k);
        run_load(DEPTH, 0);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.byte_data = 8'($urandom);
            tick();
        end
        idle(1);

        // Illegal lengths, then a legal one-word recovery.
        pulse_start(0);
        idle(2);
        pulse_start(17);
        idle(2);
        img[0] = $urandom;
        run_load(1, 0);

        // Reset part-way through the second word of a four-word load.
        for (int k = 0; k < 4; k++) img[k] = $urandom;
        pulse_start(4);
        send_words(0, 1, 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(1);
        run_load(2, 0);

        // Start during LOAD is ignored; start in DONE reloads from address 0.
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        pulse_start(3);
        send_words(0, 1, 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        pulse_start(1);
        send_byte(img[1][23:16], 0);
        send_byte(img[1][31:24], 0);
        send_words(2, 1, 0);
        idle(2);
        run_load(2, 1);

        // Randomized images, lengths, stalls and stray starts.
        for (int r = 0; r < 8; r++) begin
            nw = int'($urandom_range(1, DEPTH));
            for (int k = 0; k < DEPTH; k++) img[k] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                pulse_start(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31)));
                idle(1);
            end
            run_load(nw, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
